// File: rtl/qspi_xfer_ctrl_if.sv
// Host-side request/response bus of the quad-SPI transfer controller.
// The host drives the request and the controller returns status and read data.
interface qspi_xfer_ctrl_if #(
    parameter int unsigned NUM_CS    = 3,
    parameter int unsigned ADDR_BITS = 24
);
    localparam int unsigned CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                 start;
    logic [CS_W-1:0]      cs_sel;
    logic                 is_write;
    logic [ADDR_BITS-1:0] addr;
    logic [1:0]           len;
    logic [31:0]          wdata;
    logic                 busy;
    logic                 done;
    logic [31:0]          rdata;

    modport master (
        output start, cs_sel, is_write, addr, len, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, cs_sel, is_write, addr, len, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/qspi_xfer_ctrl.sv
// Quad-SPI transfer controller: command, address, optional dummy and 1..4 data bytes,
// one nibble per two clk cycles, with registered pin outputs.
module qspi_xfer_ctrl #(
    parameter int unsigned NUM_CS       = 3,
    parameter int unsigned ADDR_BITS    = 24,
    parameter int unsigned DUMMY_CYCLES = 4,
    parameter logic [7:0]  READ_CMD     = 8'hEB,
    parameter logic [7:0]  WRITE_CMD    = 8'h38
) (
    input  logic              clk,
    input  logic              rstn,
    qspi_xfer_ctrl_if.slave   host,
    input  logic [3:0]        spi_data_in,
    output logic [3:0]        spi_data_out,
    output logic [3:0]        spi_data_oe,
    output logic              spi_clk_out,
    output logic [NUM_CS-1:0] spi_cs_n
);
    localparam int unsigned CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int unsigned ADDR_NIB   = ADDR_BITS / 4;
    localparam logic [4:0]  ADDR_LAST  = 5'(ADDR_NIB - 1);
    localparam logic [4:0]  DUMMY_LAST = (DUMMY_CYCLES == 0) ? 5'd0 : 5'(DUMMY_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 ph_q, ph_d;
    logic [CS_W-1:0]      cs_q, cs_d;
    logic                 wr_q, wr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [1:0]           len_q, len_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          acc_q, acc_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_CS-1:0]    cs_n_q, cs_n_d;
    logic                 sclk_q, sclk_d;
    logic [3:0]           dout_q, dout_d;
    logic [3:0]           oe_q, oe_d;

    logic                 accept;
    logic                 active;
    logic [4:0]           last_nib;
    logic [4:0]           rd_off;
    logic [4:0]           wr_off;
    logic [7:0]           cmd;

    // Sequencing, then pin values derived from the next state so every pin is a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ph_d     = ph_q;
        cs_d     = cs_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wdata_d  = wdata_q;
        acc_d    = acc_q;
        rdata_d  = rdata_q;
        accept   = 1'b0;
        active   = 1'b0;
        last_nib = 5'd0;
        cmd      = READ_CMD;
        rd_off   = {cnt_q[2:1], ~cnt_q[0], 2'b00};
        wr_off   = 5'd0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        cs_n_d   = '1;
        sclk_d   = 1'b0;
        dout_d   = 4'h0;
        oe_d     = 4'h0;

        case (state_q)
            S_CMD:   last_nib = 5'd1;
            S_ADDR:  last_nib = ADDR_LAST;
            S_DUMMY: last_nib = DUMMY_LAST;
            S_DATA:  last_nib = {2'b00, len_q, 1'b1};
            default: last_nib = 5'd0;
        endcase

        case (state_q)
            S_IDLE: begin
                accept = host.start && (32'(host.cs_sel) < NUM_CS);
                if (accept) begin
                    state_d = S_CMD;
                    cnt_d   = 5'd0;
                    ph_d    = 1'b0;
                    cs_d    = host.cs_sel;
                    wr_d    = host.is_write;
                    addr_d  = host.addr;
                    len_d   = host.len;
                    wdata_d = host.wdata;
                    acc_d   = 32'd0;
                end
            end
            S_END: state_d = S_IDLE;
            default: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    // Read data is captured on the edge closing the SPI-clock-high half.
                    if (state_q == S_DATA && !wr_q)
                        acc_d[rd_off +: 4] = spi_data_in;
                    if (cnt_q == last_nib) begin
                        cnt_d = 5'd0;
                        case (state_q)
                            S_CMD:   state_d = S_ADDR;
                            S_ADDR:  state_d = (!wr_q && DUMMY_CYCLES != 0) ? S_DUMMY : S_DATA;
                            S_DUMMY: state_d = S_DATA;
                            default: begin
                                state_d = S_END;
                                if (!wr_q)
                                    rdata_d = acc_d;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
        endcase

        active = (state_d == S_CMD) || (state_d == S_ADDR) ||
                 (state_d == S_DUMMY) || (state_d == S_DATA);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_END);
        sclk_d = active && ph_d;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (active && 32'(cs_d) == i)
                cs_n_d[i] = 1'b0;
        end

        cmd    = wr_d ? WRITE_CMD : READ_CMD;
        wr_off = {cnt_d[2:1], ~cnt_d[0], 2'b00};
        case (state_d)
            S_CMD: begin
                oe_d   = 4'hF;
                dout_d = cnt_d[0] ? cmd[3:0] : cmd[7:4];
            end
            S_ADDR: begin
                oe_d   = 4'hF;
                dout_d = 4'(addr_d >> {ADDR_LAST - cnt_d, 2'b00});
            end
            S_DATA: begin
                if (wr_d) begin
                    oe_d   = 4'hF;
                    dout_d = wdata_d[wr_off +: 4];
                end
            end
            default: begin
                oe_d   = 4'h0;
                dout_d = 4'h0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            ph_q    <= 1'b0;
            cs_q    <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            len_q   <= 2'd0;
            wdata_q <= 32'd0;
            acc_q   <= 32'd0;
            rdata_q <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_n_q  <= '1;
            sclk_q  <= 1'b0;
            dout_q  <= 4'h0;
            oe_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            acc_q   <= acc_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
        end
    end

    assign host.busy    = busy_q;
    assign host.done    = done_q;
    assign host.rdata   = rdata_q;
    assign spi_cs_n     = cs_n_q;
    assign spi_clk_out  = sclk_q;
    assign spi_data_out = dout_q;
    assign spi_data_oe  = oe_q;
endmodule

// File: tb/tb_qspi_xfer_ctrl.sv
// Directed bench for qspi_xfer_ctrl with default parameters: a cycle-accurate
// host driver, a flash-side nibble responder and per-transaction pin statistics.
module tb_qspi_xfer_ctrl;
    localparam int unsigned NUM_CS    = 3;
    localparam int unsigned ADDR_BITS = 24;

    logic              clk = 1'b0;
    logic              rstn;
    logic [3:0]        spi_data_in;
    logic [3:0]        spi_data_out;
    logic [3:0]        spi_data_oe;
    logic              spi_clk_out;
    logic [NUM_CS-1:0] spi_cs_n;

    always #5 clk = ~clk;

    qspi_xfer_ctrl_if #(.NUM_CS(NUM_CS), .ADDR_BITS(ADDR_BITS)) hif ();

    qspi_xfer_ctrl #(
        .NUM_CS(NUM_CS), .ADDR_BITS(ADDR_BITS), .DUMMY_CYCLES(4),
        .READ_CMD(8'hEB), .WRITE_CMD(8'h38)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .host         (hif),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out),
        .spi_data_oe  (spi_data_oe),
        .spi_clk_out  (spi_clk_out),
        .spi_cs_n     (spi_cs_n)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Statistics gathered over one driven transaction (first transaction only where noted).
    int          cs_low, done_cnt, done_cyc, reassert, busy_cnt, cs_bad, clk_bad, oe_f, nib_n;
    logic [63:0] seq;
    logic [31:0] rd_done;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_xfer(input logic [1:0] sel, input logic wr, input logic [23:0] a,
                           input logic [1:0] ln, input logic [31:0] wd, input logic [31:0] dev,
                           input int ncyc, input bit keep_start, input int abort_at);
        logic [NUM_CS-1:0] exp_cs;
        int base, k;
        cs_low = 0; done_cnt = 0; done_cyc = 0; reassert = 0; busy_cnt = 0;
        cs_bad = 0; clk_bad = 0; oe_f = 0; nib_n = 0; seq = '0; rd_done = '0;
        exp_cs = '1;
        exp_cs[sel] = 1'b0;
        base = 2 * (2 + 6 + (wr ? 0 : 4));
        @(negedge clk);
        hif.start = 1'b1; hif.cs_sel = sel; hif.is_write = wr;
        hif.addr = a; hif.len = ln; hif.wdata = wd;
        spi_data_in = 4'h0;
        @(posedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (!keep_start) hif.start = 1'b0;
            if (spi_cs_n != '1) begin
                if (done_cnt == 0) cs_low++;
                else if (reassert == 0) reassert = c;
                if (spi_cs_n != exp_cs) cs_bad++;
            end else if (spi_clk_out) begin
                clk_bad++;
            end
            if (done_cnt == 0) begin
                if (hif.busy) busy_cnt++;
                if (spi_cs_n != '1 && spi_data_oe == 4'hF) oe_f++;
                if (spi_clk_out && spi_data_oe == 4'hF) begin
                    seq = {seq[59:0], spi_data_out};
                    nib_n++;
                end
            end
            if (hif.done) begin
                if (done_cnt == 0) begin
                    done_cyc = c;
                    rd_done  = hif.rdata;
                end
                done_cnt++;
            end
            spi_data_in = 4'h0;
            if (!wr && c > base) begin
                k = (c - base - 1) / 2;
                if (k < 2 * (int'(ln) + 1))
                    spi_data_in = 4'(dev >> (8 * (k / 2) + ((k % 2 == 0) ? 4 : 0)));
            end
            if (c == abort_at) rstn = 1'b0;
            @(posedge clk);
            if (c == abort_at) break;
        end
    endtask

    initial begin
        int bad;
        rstn = 1'b0;
        hif.start = 1'b0; hif.cs_sel = '0; hif.is_write = 1'b0;
        hif.addr = '0; hif.len = 2'd0; hif.wdata = '0;
        spi_data_in = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy_done", {hif.busy, hif.done}, 2'b00);
        check_eq("rst_rdata", hif.rdata, 32'h0);
        check_eq("rst_pins", {spi_cs_n, spi_clk_out, spi_data_out, spi_data_oe}, {3'b111, 1'b0, 8'h00});
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Quad read, 4 bytes, device 1.
        do_xfer(2'd1, 1'b0, 24'h123456, 2'd3, 32'h0, 32'h44332211, 41, 1'b0, 0);
        check_eq("rd4_cs_low", cs_low, 40);
        check_eq("rd4_cmd_addr", {nib_n, seq[31:0]}, {32'd8, 32'hEB123456});
        check_eq("rd4_done_cyc", done_cyc, 41);
        check_eq("rd4_done_cnt", done_cnt, 1);
        check_eq("rd4_rdata", rd_done, 32'h44332211);
        check_eq("rd4_busy_cyc", busy_cnt, 41);
        check_eq("rd4_oe_cycles", oe_f, 16);
        check_eq("rd4_cs_clk_bad", {cs_bad, clk_bad}, 64'd0);

        // Single-byte write, no dummy phase.
        do_xfer(2'd0, 1'b1, 24'h000010, 2'd0, 32'hDEADBEEF, 32'h0, 21, 1'b0, 0);
        check_eq("wr1_cs_low", cs_low, 20);
        check_eq("wr1_nibbles", {nib_n, seq[39:0]}, {24'd10, 40'h38000010EF});
        check_eq("wr1_oe_all", oe_f, 20);
        check_eq("wr1_done_cyc", done_cyc, 21);
        check_eq("wr1_rdata_kept", rd_done, 32'h44332211);
        check_eq("wr1_cs_clk_bad", {cs_bad, clk_bad}, 64'd0);

        // Two-byte read; upper device bytes must not leak into rdata.
        do_xfer(2'd2, 1'b0, 24'hABCDEF, 2'd1, 32'h0, 32'hFFFF5AA5, 33, 1'b0, 0);
        check_eq("rd2_cs_low", cs_low, 32);
        check_eq("rd2_done_cyc", done_cyc, 33);
        check_eq("rd2_rdata", rd_done, 32'h00005AA5);

        // Start held through busy, then an out-of-range select.
        do_xfer(2'd2, 1'b1, 24'h000000, 2'd0, 32'h0, 32'h0, 21, 1'b1, 0);
        check_eq("busy_start_done_cnt", done_cnt, 1);
        check_eq("busy_start_cs_low", cs_low, 20);
        bad = 0;
        @(negedge clk);
        hif.cs_sel = 2'd3;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (hif.busy || hif.done || spi_cs_n != '1) bad++;
        end
        hif.start = 1'b0;
        check_eq("bad_sel_ignored", bad, 0);

        // Continuous start: back-to-back transactions.
        do_xfer(2'd1, 1'b1, 24'h000004, 2'd0, 32'h000000A5, 32'h0, 24, 1'b1, 0);
        check_eq("b2b_done_cyc", done_cyc, 21);
        check_eq("b2b_reassert", reassert, done_cyc + 2);
        @(negedge clk);
        hif.start = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (hif.done) bad++;
        end
        check_eq("b2b_second_done", bad, 1);
        check_eq("b2b_idle_busy", hif.busy, 1'b0);
        check_eq("pre_abort_rdata", hif.rdata, 32'h00005AA5);

        // Reset during read DATA nibble 3.
        do_xfer(2'd0, 1'b0, 24'h000100, 2'd3, 32'h0, 32'h87654321, 41, 1'b0, 31);
        @(negedge clk);
        check_eq("abort_pins", {spi_cs_n, spi_data_oe, spi_clk_out}, {3'b111, 4'h0, 1'b0});
        check_eq("abort_busy_done", {hif.busy, hif.done, done_cnt[0]}, 3'b000);
        check_eq("abort_rdata", hif.rdata, 32'h0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
